mac_sequencer: RTL and testbench
================================

# mac_sequencer

Sequential multiply-accumulate controller that time-shares one 8-bit modulo-256 adder between the shift-add multiply steps and the final accumulate step. It accepts operand pairs over a valid/ready handshake, forms `a*b mod 256` in 8 adder passes, and adds the product into an 8-bit accumulator. It presents the new accumulator value over a second valid/ready handshake. It sits between the operand source and the result consumer, and is the sole owner and sequencer of the adder datapath.

## Interface
- `ACC_INIT`, default 8'd0: accumulator value loaded on reset.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `in_valid`, input, 1: operand pair valid.
- `in_ready`, output, 1: block can accept operands. High only in IDLE.
- `in_a`, input, 8: multiplicand, unsigned.
- `in_b`, input, 8: multiplier, unsigned.
- `clear`, input, 1: synchronous accumulator clear, sampled in IDLE only.
- `out_valid`, output, 1: `acc_out` holds the result of the last operation.
- `out_ready`, input, 1: consumer accepts the result.
- `acc_out`, output, 8: accumulator value, always driven from the accumulator register.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- Registers:
  - `acc` (8b), accumulator.
  - `p` (8b), partial product.
  - `m` (8b), shifted multiplicand.
  - `q` (8b), shifted multiplier.
  - `cnt` (3b), step counter.
  - `state`.
- One adder instance, operands muxed by state:
  - MUL: `p + m`.
  - ACC: `acc + p`.
  - The sum is modulo 256. Carry-out is discarded and no overflow flag exists.
- States: IDLE, MUL, ACC, DONE.
- IDLE:
  - `in_ready=1`.
  - On `in_valid`: load `m<=in_a`, `q<=in_b`, `p<=0`, `cnt<=0`, and go to MUL.
  - If `clear=1` on the same edge (with or without `in_valid`): `acc<=0`.
  - When clear and accept coincide, the result equals the product alone.
- MUL:
  - Each edge: if `q[0]` then `p<=p+m`. Always `m<=m<<1`, `q<=q>>1`, `cnt<=cnt+1`.
  - Always exactly 8 steps, with no early exit on `q==0`.
  - On the edge where `cnt==7`, go to ACC.
- ACC: one edge, `acc<=acc+p`, go to DONE.
- DONE:
  - `out_valid=1`.
  - Hold until `out_ready=1`, then go to IDLE on that edge.
  - `acc_out` is stable throughout DONE.
- `clear` outside IDLE is ignored. `in_valid` outside IDLE is ignored; operands are not captured.
- `in_a`/`in_b` may change freely after the accept edge, because they are captured in registers.

## Timing
- Reset values:
  - `state=IDLE`, `acc=ACC_INIT`, `p=m=q=0`, `cnt=0`.
  - Outputs: `in_ready=1`, `out_valid=0`, `busy=0`, `acc_out=ACC_INIT`.
- Reset asserted mid-operation: in-flight operation is discarded immediately (asynchronously). The accumulator returns to `ACC_INIT`, not to its pre-operation value.
- Latency (accept edge E0):
  - MUL steps on E1..E8.
  - ACC on E9.
  - `out_valid` high from after E9, i.e. 9 cycles after acceptance.
- Result handshake on edge En: state is IDLE after En, and `in_ready` is high from the cycle after En.
- Minimum throughput: 1 operation per 11 cycles when `out_ready` is tied high and `in_valid` is held high.
- Backpressure: `out_valid` stays high indefinitely while `out_ready=0`. No state or `acc` change occurs.
- `in_ready`, `out_valid` and `busy` are pure decodes of `state`. No combinational path exists from inputs to outputs.
- `out_valid` and `in_ready` are never high in the same cycle.

## Test plan
- **Basic product.** Reset, then `ACC_INIT=0`, accept `a=3, b=5` at E0.
  - Expect `acc_out=15` and `out_valid` rising after E9.
  - Expect `busy` high from after E0 until the result handshake.
- **Accumulation and wrap.**
  - Continue with `(4,4)`: expect 31.
  - Then `(20,20)` (400 mod 256 = 144): expect 175.
  - Then `(255,255)` (product mod 256 = 1): expect 176.
- **Clear with accept.**
  - With `acc=176`, assert `clear` together with `in_valid`, operands `(16,16)`: expect 0.
  - Then `clear` alone in IDLE, then `(7,9)`: expect 63.
  - Verify `clear` pulses during MUL have no effect.
- **Backpressure.**
  - Hold `out_ready=0` for 20 cycles after `out_valid` rises: `out_valid` and `acc_out` are stable, `in_ready=0`, and `in_valid` pulses are ignored.
  - Release `out_ready`: IDLE next cycle.
- **Reset mid-operation.**
  - `ACC_INIT=8'h05`, `acc=63`, accept `(9,9)`, assert `rst` during MUL step 4.
  - Expect immediate `in_ready=1`, `out_valid=0`, `busy=0`, `acc_out=5`.
  - Next `(2,3)` yields 11.
- **Zero and full-range operands.**
  - `(0,255)` yields `acc` unchanged, still after 9 cycles.
  - `(128,2)` adds 0.
  - `(1,255)` adds 255.
  - Compare every result against the reference model `acc=(acc+a*b) mod 256`.

Source files
------------

// File: rtl/mac_sequencer.sv
// Multiply-accumulate sequencer: one shared 8-bit adder performs the
// eight shift-add multiply passes and then the accumulate pass.
module mac_sequencer #(
    parameter logic [7:0] ACC_INIT = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic       clear,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] acc_out,
    output logic       busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] state;
    logic [7:0] acc;
    logic [7:0] p;
    logic [7:0] m;
    logic [7:0] q;
    logic [2:0] cnt;

    logic [7:0] add_x;
    logic [7:0] add_y;
    logic [7:0] sum;

    logic       accept;
    logic       mul_last;

    // Single adder; its operand pair is selected by the current state.
    always_comb begin
        add_x = p;
        add_y = m;
        if (state == S_ACC) begin
            add_x = acc;
            add_y = p;
        end
    end

    assign sum      = add_x + add_y;
    assign accept   = (state == S_IDLE) && in_valid;
    assign mul_last = (state == S_MUL) && (cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: if (in_valid) state <= S_MUL;
                S_MUL:  if (mul_last) state <= S_ACC;
                S_ACC:  state <= S_DONE;
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= ACC_INIT;
        end else if (state == S_IDLE && clear) begin
            acc <= 8'd0;
        end else if (state == S_ACC) begin
            acc <= sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p   <= 8'd0;
            m   <= 8'd0;
            q   <= 8'd0;
            cnt <= 3'd0;
        end else if (accept) begin
            p   <= 8'd0;
            m   <= in_a;
            q   <= in_b;
            cnt <= 3'd0;
        end else if (state == S_MUL) begin
            // Fixed eight passes; no early exit when q runs out of ones.
            if (q[0]) p <= sum;
            m   <= {m[6:0], 1'b0};
            q   <= {1'b0, q[7:1]};
            cnt <= cnt + 3'd1;
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign acc_out   = acc;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer against an arithmetic model
// acc = (acc + a*b) mod 256.
module tb_mac_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       clear;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] acc_out;
    logic       busy;

    int n_cmp;
    int n_bad;
    int model;

    localparam int INIT = 5;

    mac_sequencer #(.ACC_INIT(8'h05)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .clear(clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc_out(acc_out),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_only();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model = 0;
        chk("clear_idle", acc_out, 0);
        chk("clear_idle_rdy", in_ready, 1);
    endtask

    // One full operation; noise drives ignored inputs while busy,
    // bp holds the result for 20 cycles before taking it.
    task automatic do_op(input int a, input int b, input bit clr,
                         input bit noise, input bit bp);
        int n;
        chk("pre_rdy", in_ready, 1);
        in_a = 8'(a);
        in_b = 8'(b);
        clear = clr;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        clear = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        if (clr) model = 0;
        model = (model + a * b) % 256;
        chk("busy_after_accept", busy, 1);
        chk("rdy_after_accept", in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            if (noise) begin
                clear = 1'($urandom);
                in_valid = 1'($urandom);
                in_a = 8'($urandom);
                in_b = 8'($urandom);
            end
            tick();
            n++;
        end
        chk("latency", n, 9);
        chk("result", acc_out, model);
        chk("busy_done", busy, 1);
        chk("rdy_done", in_ready, 0);
        if (bp) begin
            for (int i = 0; i < 20; i++) begin
                in_valid = 1'($urandom);
                clear = 1'($urandom);
                in_a = 8'($urandom);
                tick();
                chk("bp_valid", out_valid, 1);
                chk("bp_acc", acc_out, model);
                chk("bp_rdy", in_ready, 0);
            end
        end
        in_valid = 1'b0;
        clear = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_rdy", in_ready, 1);
        chk("post_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_acc", acc_out, model);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 8'd0;
        in_b = 8'd0;
        clear = 1'b0;
        out_ready = 1'b0;
        #12;
        rst = 1'b0;
        model = INIT;
        tick();
        chk("rst_rdy", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acc", acc_out, INIT);

        clear_only();
        do_op(3, 5, 0, 0, 0);
        chk("basic_15", acc_out, 15);
        do_op(4, 4, 0, 0, 0);
        chk("acc_31", acc_out, 31);
        do_op(20, 20, 0, 0, 0);
        chk("wrap_175", acc_out, 175);
        do_op(255, 255, 0, 0, 0);
        chk("wrap_176", acc_out, 176);
        do_op(16, 16, 1, 0, 0);
        chk("clr_accept_0", acc_out, 0);
        clear_only();
        do_op(7, 9, 0, 1, 1);
        chk("noise_bp_63", acc_out, 63);

        // reset during MUL step 4
        in_a = 8'd9;
        in_b = 8'd9;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_rdy", in_ready, 1);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_acc", acc_out, INIT);
        #2;
        rst = 1'b0;
        model = INIT;
        tick();
        do_op(2, 3, 0, 0, 0);
        chk("after_rst_11", acc_out, 11);

        do_op(0, 255, 0, 0, 0);
        chk("zero_op", acc_out, 11);
        do_op(128, 2, 0, 0, 0);
        chk("add_zero", acc_out, 11);
        do_op(1, 255, 0, 0, 0);
        chk("add_255", acc_out, 10);

        for (int k = 0; k < 25; k++) begin
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 5) == 0), bit'($urandom),
                  bit'($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
